// File: rtl/countdown_timer.sv
// MM:SS countdown timer driven by a 1 Hz tick strobe; flags expiry with a level and a one-cycle pulse.
// Optional COUNTDOWN_AUTO_RELOAD_EN: restart from the loaded duration on reaching 00:00 instead of expiring.
module countdown_timer #(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       clear,
  input  logic       load,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [6:0] MAX_MIN_C = 7'(MAX_MIN);
  localparam logic [5:0] SEC_MAX_C = 6'd59;

  function automatic logic [6:0] clamp_min(input logic [6:0] value);
    return (value > MAX_MIN_C) ? MAX_MIN_C : value;
  endfunction

  function automatic logic [5:0] clamp_sec(input logic [5:0] value);
    return (value > SEC_MAX_C) ? SEC_MAX_C : value;
  endfunction

  state_t     state_r, state_nx_s;
  logic [6:0] min_r, min_nx_s, dec_min_s;
  logic [5:0] sec_r, sec_nx_s, dec_sec_s;
  logic       running_r, expired_r, done_r, done_nx_s;
  logic       load_ok_s, start_ok_s, pause_ok_s, tick_ok_s, dec_zero_s;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [6:0] rld_min_r, rld_min_nx_s;
  logic [5:0] rld_sec_r, rld_sec_nx_s;
`endif

  // Which commands the current state accepts
  always_comb begin
    load_ok_s  = 1'b0;
    start_ok_s = 1'b0;
    pause_ok_s = 1'b0;
    tick_ok_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_ok_s  = load;
        start_ok_s = start && ((min_r != 7'd0) || (sec_r != 6'd0));
      end
      ST_RUNNING: begin
        pause_ok_s = pause;
        tick_ok_s  = tick;
      end
      ST_PAUSED: begin
        load_ok_s  = load;
        start_ok_s = start && ((min_r != 7'd0) || (sec_r != 6'd0));
      end
      ST_EXPIRED: begin
        load_ok_s  = load;
      end
      default: begin
        load_ok_s  = 1'b0;
      end
    endcase
  end

  // One-second decrement with borrow from minutes
  always_comb begin
    dec_min_s = min_r;
    dec_sec_s = sec_r;
    if (sec_r != 6'd0) begin
      dec_sec_s = sec_r - 6'd1;
    end else if (min_r != 7'd0) begin
      dec_min_s = min_r - 7'd1;
      dec_sec_s = SEC_MAX_C;
    end else begin
      dec_sec_s = sec_r;
    end
    dec_zero_s = (dec_min_s == 7'd0) && (dec_sec_s == 6'd0);
  end

  // Next-state and next-count selection, clear > load > start > pause > tick
  always_comb begin
    state_nx_s = state_r;
    min_nx_s   = min_r;
    sec_nx_s   = sec_r;
    done_nx_s  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    rld_min_nx_s = rld_min_r;
    rld_sec_nx_s = rld_sec_r;
`endif
    if (clear) begin
      state_nx_s = ST_IDLE;
      min_nx_s   = 7'd0;
      sec_nx_s   = 6'd0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      rld_min_nx_s = 7'd0;
      rld_sec_nx_s = 6'd0;
`endif
    end else if (load_ok_s) begin
      state_nx_s = ST_IDLE;
      min_nx_s   = clamp_min(load_min);
      sec_nx_s   = clamp_sec(load_sec);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      rld_min_nx_s = clamp_min(load_min);
      rld_sec_nx_s = clamp_sec(load_sec);
`endif
    end else if (start_ok_s) begin
      state_nx_s = ST_RUNNING;
    end else if (pause_ok_s) begin
      state_nx_s = ST_PAUSED;
    end else if (tick_ok_s) begin
      if (dec_zero_s) begin
        done_nx_s = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        min_nx_s  = rld_min_r;
        sec_nx_s  = rld_sec_r;
`else
        min_nx_s   = 7'd0;
        sec_nx_s   = 6'd0;
        state_nx_s = ST_EXPIRED;
`endif
      end else begin
        min_nx_s = dec_min_s;
        sec_nx_s = dec_sec_s;
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // State, count and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      min_r     <= 7'd0;
      sec_r     <= 6'd0;
      running_r <= 1'b0;
      expired_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      min_r     <= min_nx_s;
      sec_r     <= sec_nx_s;
      running_r <= (state_nx_s == ST_RUNNING);
      expired_r <= (state_nx_s == ST_EXPIRED);
      done_r    <= done_nx_s;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Duration captured by load, restored on each wrap to 00:00
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rld_min_r <= 7'd0;
      rld_sec_r <= 6'd0;
    end else begin
      rld_min_r <= rld_min_nx_s;
      rld_sec_r <= rld_sec_nx_s;
    end
  end
`endif

  assign minutes = min_r;
  assign seconds = sec_r;
  assign running = running_r;
  assign expired = expired_r;
  assign done    = done_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: total-seconds reference model checked every cycle, directed scenarios, random traffic.
// Honours COUNTDOWN_AUTO_RELOAD_EN the same way as the design.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst, tick, clear, load, start, pause;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       running, expired, done;

  countdown_timer #(.MAX_MIN(99)) dut (
    .clk(clk), .rst(rst), .tick(tick), .clear(clear), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
    .minutes(minutes), .seconds(seconds), .running(running),
    .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
  localparam int MAXM = 99;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: remaining time as a single number of seconds
  int m_total  = 0;
  int m_reload = 0;
  int m_state  = S_IDLE;
  bit m_done   = 1'b0;

  task automatic model_step();
    int mm, ss;
    if (rst) begin
      m_total = 0; m_reload = 0; m_state = S_IDLE; m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (clear) begin
      m_total = 0; m_reload = 0; m_state = S_IDLE;
    end else if (load && m_state != S_RUN) begin
      mm = (int'(load_min) > MAXM) ? MAXM : int'(load_min);
      ss = (int'(load_sec) > 59) ? 59 : int'(load_sec);
      m_total = mm * 60 + ss; m_reload = m_total; m_state = S_IDLE;
    end else if (start && (m_state == S_IDLE || m_state == S_PAUSE) && m_total != 0) begin
      m_state = S_RUN;
    end else if (pause && m_state == S_RUN) begin
      m_state = S_PAUSE;
    end else if (tick && m_state == S_RUN) begin
      m_total = m_total - 1;
      if (m_total == 0) begin
        m_done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        m_total = m_reload;
`else
        m_state = S_EXP;
`endif
      end
    end
  endtask

  // Every-cycle comparison against the reference model
  always @(negedge clk) begin
    n_checks++;
    if (minutes !== 7'(m_total / 60) || seconds !== 6'(m_total % 60) ||
        running !== (m_state == S_RUN) || expired !== (m_state == S_EXP) ||
        done !== m_done) begin
      $display("FAIL model_cmp t=%0t got %0d:%0d run=%0b exp=%0b done=%0b want %0d:%0d state=%0d done=%0b",
               $time, minutes, seconds, running, expired, done,
               m_total / 60, m_total % 60, m_state, m_done);
    end else begin
      n_pass++;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) $display("FAIL %s got %0d want %0d", name, got, want);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit c, input bit l, input int lm, input int ls,
                       input bit s, input bit p, input bit t);
    clear = c; load = l; load_min = 7'(lm); load_sec = 6'(ls);
    start = s; pause = p; tick = t;
    cyc();
    clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic hit_reset();
    #2 rst = 1'b1;
    model_step();
    @(negedge clk);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_min = 7'd0; load_sec = 6'd0;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_min", int'(minutes), 0);
    chk("reset_run", int'(running), 0);

    // Reset in the middle of a run
    drive(1'b0, 1'b1, 1, 30, 1'b0, 1'b0, 1'b0);
    chk("load_0130_min", int'(minutes), 1);
    chk("load_0130_sec", int'(seconds), 30);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    chk("run_0125_sec", int'(seconds), 25);
    hit_reset();
    chk("midrun_rst_sec", int'(seconds), 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("start_at_zero_run", int'(running), 0);

    // Borrow across the minute boundary down to 00:00
    drive(1'b0, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("borrow_min", int'(minutes), 1);
    chk("borrow_sec", int'(seconds), 59);
    ticks(118);
    chk("one_left_sec", int'(seconds), 1);
    chk("one_left_done", int'(done), 0);
    ticks(1);
    chk("expiry_done", int'(done), 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    chk("wrap_min", int'(minutes), 2);
    chk("wrap_run", int'(running), 1);
`else
    chk("expiry_sec", int'(seconds), 0);
    chk("expiry_flag", int'(expired), 1);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("start_in_expired", int'(running), 0);
`endif
    chk("done_one_cycle", int'(done), 0);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Clamping and the zero-start guard
    drive(1'b0, 1'b1, 120, 63, 1'b0, 1'b0, 1'b0);
    chk("clamp_min", int'(minutes), 99);
    chk("clamp_sec", int'(seconds), 59);
    drive(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("zero_start_run", int'(running), 0);

    // Pause priority and resume without decrement
    drive(1'b0, 1'b1, 0, 10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    chk("pause_pre_sec", int'(seconds), 7);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    chk("pause_tick_sec", int'(seconds), 7);
    chk("pause_tick_run", int'(running), 0);
    ticks(3);
    chk("paused_hold_sec", int'(seconds), 7);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    chk("resume_run", int'(running), 1);
    chk("resume_sec", int'(seconds), 7);
    ticks(1);
    chk("resume_tick_sec", int'(seconds), 6);

    // Load ignored while running, clear wins
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 0, 5, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 0, 30, 1'b0, 1'b0, 1'b0);
    chk("load_in_run_sec", int'(seconds), 5);
    chk("load_in_run_run", int'(running), 1);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("clear_run_sec", int'(seconds), 0);
    chk("clear_run_run", int'(running), 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    drive(1'b0, 1'b1, 0, 3, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    chk("reload_done1", int'(done), 1);
    chk("reload_sec", int'(seconds), 3);
    chk("reload_exp", int'(expired), 0);
    ticks(3);
    chk("reload_done2", int'(done), 1);
`endif

    // Reset while done is pulsing
    drive(1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("pulse_before_rst", int'(done), 1);
    hit_reset();
    chk("pulse_after_rst", int'(done), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        hit_reset();
      end else begin
        clear    = ($urandom_range(0, 63) == 0);
        load     = ($urandom_range(0, 15) == 0);
        load_min = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 2));
        load_sec = 6'($urandom_range(0, 63));
        start    = ($urandom_range(0, 7) == 0);
        pause    = ($urandom_range(0, 15) == 0);
        tick     = ($urandom_range(0, 1) == 1);
        cyc();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Down-counting MM:SS timer, the decrementing counterpart to the up-counting seconds/minutes chain in the clock datapath. Consumes the same one-cycle 1 Hz `tick` qualifier, counts a loaded duration down to 00:00, then flags expiry with a level and a single-cycle pulse. Sits beside the timekeeping counters and feeds the alarm/buzzer control logic.

## Interface
- `MAX_MIN`, default 99: largest loadable minutes value; must be ≤ 127.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle count qualifier (1 Hz strobe); ignored unless RUNNING.
- `clear`  in  1  synchronous clear to 00:00, IDLE.
- `load`  in  1  capture `load_min`/`load_sec` as the new duration.
- `load_min`  in  7  minutes to load.
- `load_sec`  in  6  seconds to load.
- `start`  in  1  begin/resume counting.
- `pause`  in  1  hold the count.
- `minutes`  out  7  current minutes remaining.
- `seconds`  out  6  current seconds remaining, 0–59.
- `running`  out  1  high in RUNNING.
- `expired`  out  1  high in EXPIRED.
- `done`  out  1  one-cycle pulse when the count reaches 00:00.

## Operation
- States: IDLE, RUNNING, PAUSED, EXPIRED. Reset → IDLE.
- Input priority within a cycle: `clear` > `load` > `start` > `pause`.
- `clear`: any state → IDLE, count 00:00, reload register 00:00.
- `load`: accepted in IDLE, PAUSED and EXPIRED; ignored in RUNNING. Clamps `load_sec` > 59 to 59 and `load_min` > `MAX_MIN` to `MAX_MIN`. Writes both the count and the reload register. Next state is IDLE.
- `start`: IDLE or PAUSED → RUNNING, only if the count is not 00:00; otherwise ignored. `start` in EXPIRED is ignored; the duration must be reloaded first.
- `pause`: RUNNING → PAUSED. The count holds, and `tick` is ignored.
- On `tick` in RUNNING:
  - If `seconds` > 0: decrement `seconds`.
  - Else if `minutes` > 0: decrement `minutes` and set `seconds` to 59.
  - If the updated value is 00:00: pulse `done` and apply the expiry rule (see Configuration).
- `tick` coincident with `pause`: `pause` wins and no decrement occurs.
- `tick` coincident with `start` from PAUSED: the state moves to RUNNING and no decrement occurs that cycle.
- Arithmetic is modulo-free. The count never underflows, because RUNNING is never entered at 00:00.

## Timing
- All outputs are registered. Reset values: `minutes`=0, `seconds`=0, `running`=0, `expired`=0, `done`=0; state IDLE.
- Control inputs and `tick` are sampled at edge N; the count and state update at edge N, visible in cycle N+1.
- `done` is high only in the cycle following the edge that wrote 00:00. `expired` rises in that same cycle.
- `load` → new value visible on `minutes`/`seconds` one cycle later.
- Assertion of `rst` at any time (mid-count, mid-pulse) forces the reset values immediately. There is no pending `done` after release.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` defined:
  - On reaching 00:00, the count reloads from the reload register at the same edge and the state stays RUNNING. `done` still pulses for one cycle, and `expired` is never asserted.
  - A reload register of 00:00 cannot occur in RUNNING.
- `COUNTDOWN_AUTO_RELOAD_EN` undefined:
  - On reaching 00:00, the state moves to EXPIRED with the count held at 00:00.
  - `expired` stays high until `clear` or `load`.

## Test plan
- Reset mid-run: load 01:30, start, 5 ticks, assert `rst` → all outputs 0, IDLE; `start` afterwards is ignored (count 00:00).
- Borrow: load 02:00, start, 1 tick → 01:59; 119 more ticks → 00:00, `done` high exactly 1 cycle, `expired`=1 (macro off).
- Clamp and guard: load `load_min`=120, `load_sec`=63 with `MAX_MIN`=99 → 99:59. Load 00:00, then start → stays IDLE, `running`=0.
- Pause/priority: load 00:10, start, 3 ticks → 00:07. Pause asserted with tick → holds 00:07; ticks while PAUSED ignored. `start`+`tick` → RUNNING, still 00:07; next tick → 00:06.
- Load ignored while running: load 00:05, start, assert load with 00:30 → count unaffected. Clear while RUNNING → 00:00, IDLE next cycle.
- Auto reload (macro on): load 00:03, start, 3 ticks → `done` pulse, count 00:03, `running`=1, `expired`=0. 3 more ticks → second `done` pulse.
